imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
REQ-002 Port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-004 Port: start  input  1  single-cycle request to begin a program load.
REQ-005 Port: num_words  input  ADDR_W+1  program length in 32-bit words; sampled only on an accepted start.
REQ-006 Port: byte_valid  input  1  byte_data holds a valid program byte.
REQ-007 Port: byte_data  input  8  program byte; words arrive little-endian, least-significant byte first.
REQ-008 Port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 Port: imem_addr  output  ADDR_W  word address for the write.
REQ-011 Port: imem_wdata  output  32  assembled instruction word.
REQ-012 Port: cpu_reset  output  1  active-high hold-in-reset to the CPU; high except in DONE.
REQ-013 Port: busy  output  1  load in progress (RECV or WRITE).
REQ-014 Port: done  output  1  program fully written, CPU released.
REQ-015 Port: error  output  1  sticky flag: last start had an illegal num_words.

Function
REQ-016 FSM states: IDLE, RECV, WRITE, DONE; outputs decoded from the state register only (Moore).
REQ-017 byte_ready = (state==RECV); imem_we = (state==WRITE); busy = RECV|WRITE; done = (state==DONE); cpu_reset = (state!=DONE).
REQ-018 Byte transfer occurs only on cycles with byte_valid && byte_ready; byte_valid in any other state is ignored, no byte consumed.
REQ-019 IDLE/DONE + start with 1 <= num_words <= DEPTH: latch N = num_words, word address = 0, byte index = 0, clear error, go RECV next cycle.
REQ-020 IDLE/DONE + start with num_words == 0 or > DEPTH: set error, go/stay IDLE (cpu_reset high), no memory write.
REQ-021 start in RECV or WRITE is ignored; N and address are unaffected.
REQ-022 RECV: byte index k (0..3) places byte_data into imem_wdata[8k+7:8k]; index increments by 1 per transfer.
REQ-023 Transfer of byte index 3 moves FSM to WRITE on the next edge; index wraps to 0.
REQ-024 WRITE lasts exactly one cycle: imem_we=1, imem_addr = current word address, imem_wdata = assembled word, stable that cycle.
REQ-025 Leaving WRITE: if address == N-1 go DONE; else address increments by 1 and go RECV.
REQ-026 Peak throughput: 4 bytes in 4 consecutive cycles, then 1 WRITE cycle (byte_ready low) -> 5 cycles per word.
REQ-027 Address never exceeds N-1 and never wraps past DEPTH-1; a full DEPTH-word load ends at address DEPTH-1.
REQ-028 DONE holds done=1, cpu_reset=0 until a new start; valid start re-enters RECV and re-asserts cpu_reset the next cycle.
REQ-029 imem_wdata holds its last value outside WRITE; consumers qualify with imem_we only.

Reset
REQ-030 reset low asynchronously forces: state IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, byte index 0, N=0, busy=0, done=0, error=0, cpu_reset=1.
REQ-031 reset asserted mid-load (RECV or WRITE) discards the partial word; no write occurs after reset assertion; post-reset load restarts at address 0.
REQ-032 First start is honoured on the first rising edge after reset deasserts.

Verification
REQ-033 Reset: reset=0 for 2 cycles -> cpu_reset=1, imem_we=0, done=0, error=0, byte_ready=0.
REQ-034 Two-word load: start, num_words=2, bytes 13,00,50,00 then B3,02,40,00 back-to-back -> imem_we at addr 0 data 0x00500013, addr 1 data 0x004002B3, then done=1, cpu_reset=0; exactly 2 writes.
REQ-035 Throttled source: byte_valid toggled every other cycle, num_words=1, bytes EF,BE,AD,DE -> single write addr 0 data 0xDEADBEEF; no byte dropped or duplicated.
REQ-036 Illegal length: start with num_words=0, then num_words=DEPTH+1 -> error=1, state IDLE, no imem_we; following valid start clears error.
REQ-037 Mid-load reset: num_words=3, reset pulsed low after 6 bytes -> at most one write (addr 0), outputs at reset values; a new 1-word load writes addr 0.
REQ-038 Full depth + reload: num_words=DEPTH, last write addr DEPTH-1 then DONE; start during RECV ignored; start in DONE re-asserts cpu_reset and restarts at addr 0.

Source files
------------

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// imem_loader : byte-stream program loader for instruction memory; holds CPU
// in reset until the full image is written.           Revision 1.0
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                error_q, error_d;
  logic                byte_ready_q, imem_we_q, busy_q, done_q, cpu_reset_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    error_d = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if ((num_words != '0) && (num_words <= DEPTH)) begin
            n_d     = num_words;
            addr_d  = '0;
            idx_d   = '0;
            error_d = 1'b0;
            state_d = S_RECV;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RECV: begin
        if (byte_valid) begin
          wdata_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // n_q is at least 1 here, so N-1 never underflows
        if ({1'b0, addr_q} == (n_q - (ADDR_W+1)'(1))) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      error_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      error_q      <= error_d;
      byte_ready_q <= (state_d == S_RECV);
      imem_we_q    <= (state_d == S_WRITE);
      busy_q       <= (state_d == S_RECV) || (state_d == S_WRITE);
      done_q       <= (state_d == S_DONE);
      cpu_reset_q  <= (state_d != S_DONE);
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_loader : directed table-driven bench for imem_loader.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          CLK = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_W(AW)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  always @(negedge CLK) if (imem_we === 1'b1) wr_count++;

  typedef struct packed {
    logic        st;
    logic [6:0]  nw;
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;
    logic        we;
    logic        bsy;
    logic        dn;
    logic        crst;
    logic        err;
    logic [5:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mkv(input logic st, input logic [6:0] nw, input logic bv,
                               input logic [7:0] bd, input logic rdy, input logic we,
                               input logic bsy, input logic dn, input logic crst,
                               input logic err, input logic [5:0] addr, input logic [31:0] data);
    mkv = {st, nw, bv, bd, rdy, we, bsy, dn, crst, err, addr, data};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string name, input logic rdy, input logic we, input logic bsy,
                           input logic dn, input logic crst, input logic err);
    check(name, {58'd0, byte_ready, imem_we, busy, done, cpu_reset, error},
          {58'd0, rdy, we, bsy, dn, crst, err});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    idle_in();
    while (!byte_ready && t < 20) begin
      step();
      t++;
    end
    if (!byte_ready) check("ready_timeout", {63'd0, byte_ready}, 64'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    step();
    idle_in();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_write(input string name, input logic [5:0] a, input logic [31:0] d);
    int t;
    t = 0;
    while (!imem_we && t < 10) begin
      step();
      t++;
    end
    check({name, "_we"},   {63'd0, imem_we}, 64'd1);
    check({name, "_addr"}, {58'd0, imem_addr}, {58'd0, a});
    check({name, "_data"}, {32'd0, imem_wdata}, {32'd0, d});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    vec_t v;

    // Two-word load, byte_valid held high through the WRITE cycle (junk FF ignored)
    vecs[0]  = mkv(1, 7'd2, 0, 8'h00, 1, 0, 1, 0, 1, 0, 6'd0, 32'h0);
    vecs[1]  = mkv(0, 7'd0, 1, 8'h13, 1, 0, 1, 0, 1, 0, 6'd0, 32'h0);
    vecs[2]  = mkv(0, 7'd0, 1, 8'h00, 1, 0, 1, 0, 1, 0, 6'd0, 32'h0);
    vecs[3]  = mkv(0, 7'd0, 1, 8'h50, 1, 0, 1, 0, 1, 0, 6'd0, 32'h0);
    vecs[4]  = mkv(0, 7'd0, 1, 8'h00, 0, 1, 1, 0, 1, 0, 6'd0, 32'h00500013);
    vecs[5]  = mkv(0, 7'd0, 1, 8'hFF, 1, 0, 1, 0, 1, 0, 6'd1, 32'h0);
    vecs[6]  = mkv(0, 7'd0, 1, 8'hB3, 1, 0, 1, 0, 1, 0, 6'd1, 32'h0);
    vecs[7]  = mkv(0, 7'd0, 1, 8'h02, 1, 0, 1, 0, 1, 0, 6'd1, 32'h0);
    vecs[8]  = mkv(0, 7'd0, 1, 8'h40, 1, 0, 1, 0, 1, 0, 6'd1, 32'h0);
    vecs[9]  = mkv(0, 7'd0, 1, 8'h00, 0, 1, 1, 0, 1, 0, 6'd1, 32'h004002B3);
    vecs[10] = mkv(0, 7'd0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 6'd1, 32'h0);
    vecs[11] = mkv(0, 7'd0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 6'd1, 32'h0);

    reset = 1'b0;
    idle_in();
    repeat (2) @(posedge CLK);
    #1;
    check_ctl("reset_ctl", 0, 0, 0, 0, 1, 0);
    check("reset_addr", {58'd0, imem_addr}, 64'd0);
    check("reset_data", {32'd0, imem_wdata}, 64'd0);
    reset = 1'b1;

    // Table-driven two-word load starting on the first edge after reset release
    wr0 = wr_count;
    for (int i = 0; i < 12; i++) begin
      v          = vecs[i];
      start      = v.st;
      num_words  = v.nw;
      byte_valid = v.bv;
      byte_data  = v.bd;
      step();
      check_ctl($sformatf("vec%0d_ctl", i), v.rdy, v.we, v.bsy, v.dn, v.crst, v.err);
      check($sformatf("vec%0d_addr", i), {58'd0, imem_addr}, {58'd0, v.addr});
      if (v.we) check($sformatf("vec%0d_data", i), {32'd0, imem_wdata}, {32'd0, v.data});
    end
    idle_in();
    check("two_word_writes", 64'(wr_count - wr0), 64'd2);

    // Throttled source: valid every other cycle, junk data while invalid
    wr0 = wr_count;
    start = 1'b1; num_words = 7'd1;
    step();
    idle_in();
    check_ctl("thr_start", 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      byte_valid = (i % 2 == 0);
      case (i)
        0: byte_data = 8'hEF;
        2: byte_data = 8'hBE;
        4: byte_data = 8'hAD;
        6: byte_data = 8'hDE;
        default: byte_data = 8'h55;
      endcase
      step();
    end
    idle_in();
    expect_write("thr", 6'd0, 32'hDEADBEEF);
    step();
    check_ctl("thr_done", 0, 0, 0, 1, 0, 0);
    check("thr_writes", 64'(wr_count - wr0), 64'd1);

    // Illegal lengths from DONE: zero and DEPTH+1
    wr0 = wr_count;
    start = 1'b1; num_words = 7'd0;
    step();
    check_ctl("ill_zero", 0, 0, 0, 0, 1, 1);
    num_words = 7'(DEPTH + 1);
    step();
    idle_in();
    check_ctl("ill_over", 0, 0, 0, 0, 1, 1);
    step();
    check_ctl("ill_hold", 0, 0, 0, 0, 1, 1);
    check("ill_writes", 64'(wr_count - wr0), 64'd0);
    start = 1'b1; num_words = 7'd1;
    step();
    idle_in();
    check_ctl("ill_clear", 1, 0, 1, 0, 1, 0);
    send_word(32'hCAFEF00D);
    expect_write("ill_ok", 6'd0, 32'hCAFEF00D);
    step();
    check_ctl("ill_done", 0, 0, 0, 1, 0, 0);

    // Asynchronous reset after 6 bytes of a 3-word load
    start = 1'b1; num_words = 7'd3;
    step();
    idle_in();
    wr0 = wr_count;
    send_word(32'h11111111);
    expect_write("mid_w0", 6'd0, 32'h11111111);
    send_byte(8'h77);
    send_byte(8'h88);
    #2 reset = 1'b0;
    #1;
    check_ctl("mid_rst_ctl", 0, 0, 0, 0, 1, 0);
    check("mid_rst_addr", {58'd0, imem_addr}, 64'd0);
    check("mid_rst_data", {32'd0, imem_wdata}, 64'd0);
    repeat (2) step();
    check("mid_rst_writes", 64'(wr_count - wr0), 64'd1);
    reset = 1'b1;
    start = 1'b1; num_words = 7'd1;
    step();
    idle_in();
    send_word(32'h44332211);
    expect_write("mid_reload", 6'd0, 32'h44332211);
    step();
    check_ctl("mid_done", 0, 0, 0, 1, 0, 0);

    // Full-depth load with an ignored start during RECV, then reload from DONE
    start = 1'b1; num_words = 7'(DEPTH);
    step();
    num_words = 7'd5;
    step();
    idle_in();
    check_ctl("full_start_ign", 1, 0, 1, 0, 1, 0);
    wr0 = wr_count;
    for (int i = 0; i < DEPTH; i++) begin
      send_word(32'hA5000000 | 32'(i));
      expect_write($sformatf("full_w%0d", i), 6'(i), 32'hA5000000 | 32'(i));
    end
    step();
    check_ctl("full_done", 0, 0, 0, 1, 0, 0);
    check("full_last_addr", {58'd0, imem_addr}, 64'(DEPTH - 1));
    check("full_writes", 64'(wr_count - wr0), 64'(DEPTH));
    start = 1'b1; num_words = 7'd1;
    step();
    idle_in();
    check_ctl("reload_ctl", 1, 0, 1, 0, 1, 0);
    send_word(32'h0BADC0DE);
    expect_write("reload", 6'd0, 32'h0BADC0DE);
    step();
    check_ctl("reload_done", 0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
